// File: rtl/uart_boot_loader.sv
// UART (8N1) program loader: header 0xA5, LEN, then LEN little-endian words into instruction memory; BOOT_CHECKSUM_EN adds a trailing checksum byte.
// Write strobe lands one cycle after the 4th byte of a word; no backpressure, the UART cannot be stalled so bytes are consumed as they arrive.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10,
  parameter int MAX_WORDS    = 256
) (
  input  logic              CLOCK_50,
  input  logic              RESET_L,
  input  logic              uart_rx,
  output logic              instr_we,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [31:0]       instr_wdata,
  output logic              core_run,
  output logic              boot_busy,
  output logic              boot_error,
  output logic [15:0]       words_loaded
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK, ST_DONE, ST_ERR} st_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DONE, ST_ERR} st_t;
`endif

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_rx_byte;
  logic             r_byte_vld;
  logic             r_frame_err;

  st_t              r_state;
  logic [7:0]       r_len_lo;
  logic [15:0]      r_len;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_asm;
  logic             r_instr_we;
  logic [ADDR_W-1:0] r_instr_addr;
  logic [31:0]      r_instr_wdata;
  logic             r_core_run, r_boot_busy, r_boot_error;
  logic [15:0]      r_words;

  logic [15:0]      w_len;
  logic [15:0]      w_words_nxt;
  assign w_len       = {r_rx_byte, r_len_lo};
  assign w_words_nxt = r_words + 16'd1;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_nxt;
  assign w_sum_nxt = r_sum + r_rx_byte;
`endif

  // Receiver: byte_vld / frame_err pulse at the mid-point of the stop bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_bit_idx   <= '0;
      r_rx_shift  <= '0;
      r_rx_byte   <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= uart_rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_M1) begin
            r_rx_cnt  <= '0;
            r_bit_idx <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == FULL_M1) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == FULL_M1) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte_vld <= 1'b1;
              r_rx_byte  <= r_rx_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // core_run rises a cycle after entering DONE so it never overlaps the last write.
  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state       <= ST_IDLE;
      r_len_lo      <= '0;
      r_len         <= '0;
      r_byte_cnt    <= '0;
      r_asm         <= '0;
      r_instr_we    <= 1'b0;
      r_instr_addr  <= '0;
      r_instr_wdata <= '0;
      r_core_run    <= 1'b0;
      r_boot_busy   <= 1'b0;
      r_boot_error  <= 1'b0;
      r_words       <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_instr_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_byte_vld && r_rx_byte == 8'hA5) begin
            r_state     <= ST_LEN_LO;
            r_boot_busy <= 1'b1;
            r_byte_cnt  <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum       <= '0;
`endif
          end
        end
        ST_LEN_LO: begin
          if (r_frame_err) begin
            r_state <= ST_ERR; r_boot_error <= 1'b1; r_boot_busy <= 1'b0;
          end else if (r_byte_vld) begin
            r_len_lo <= r_rx_byte;
            r_state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (r_frame_err) begin
            r_state <= ST_ERR; r_boot_error <= 1'b1; r_boot_busy <= 1'b0;
          end else if (r_byte_vld) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= ST_CHK;
`else
              r_state <= ST_DONE; r_boot_busy <= 1'b0;
`endif
            end else if (w_len > 16'(MAX_WORDS)) begin
              r_state <= ST_ERR; r_boot_error <= 1'b1; r_boot_busy <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (r_frame_err) begin
            r_state <= ST_ERR; r_boot_error <= 1'b1; r_boot_busy <= 1'b0;
          end else if (r_byte_vld) begin
            r_asm      <= {r_rx_byte, r_asm[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            r_sum      <= w_sum_nxt;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_instr_we    <= 1'b1;
              r_instr_wdata <= {r_rx_byte, r_asm};
              r_instr_addr  <= ADDR_W'({r_words, 2'b00});
              r_words       <= w_words_nxt;
              if (w_words_nxt == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                r_state <= ST_CHK;
`else
                r_state <= ST_DONE; r_boot_busy <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHK: begin
          if (r_frame_err) begin
            r_state <= ST_ERR; r_boot_error <= 1'b1; r_boot_busy <= 1'b0;
          end else if (r_byte_vld) begin
            if (w_sum_nxt == 8'd0) begin
              r_state <= ST_DONE; r_boot_busy <= 1'b0;
            end else begin
              r_state <= ST_ERR; r_boot_error <= 1'b1; r_boot_busy <= 1'b0;
            end
          end
        end
`endif
        ST_DONE: begin
          r_core_run  <= 1'b1;
          r_boot_busy <= 1'b0;
        end
        ST_ERR: begin
          r_core_run   <= 1'b0;
          r_boot_busy  <= 1'b0;
          r_boot_error <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_we     = r_instr_we;
  assign instr_addr   = r_instr_addr;
  assign instr_wdata  = r_instr_wdata;
  assign core_run     = r_core_run;
  assign boot_busy    = r_boot_busy;
  assign boot_error   = r_boot_error;
  assign words_loaded = r_words;

endmodule
